dot_product_seq: RTL and testbench

- Sequencing controller that sits directly upstream of the single-product multiplier unit (start/done, a/b, 32-bit result) and drives it as a called function.
- Accepts a stream of operand pairs terminated by a last flag and issues one multiplier call per pair.
- Accumulates the returned products and emits one sum per vector on a valid/ready output.
- Watchdog aborts a vector if the multiplier never answers.

---
 rtl/dot_product_seq_if.sv | 35 +++
 rtl/dot_product_seq.sv | 159 +++++++++++++++
 tb/tb_dot_product_seq.sv | 246 ++++++++++++++++++++++++
 3 files changed

// File: rtl/dot_product_seq_if.sv
// Bundles the operand stream, the result stream and the multiplier call port of
// dot_product_seq. The slave modport is the sequencer's view.
interface dot_product_seq_if #(
    parameter int unsigned WIDTH     = 32,
    parameter int unsigned ACC_WIDTH = 40,
    parameter int unsigned CNT_WIDTH = 16
);
    logic                 in_valid;
    logic                 in_ready;
    logic [WIDTH-1:0]     in_a;
    logic [WIDTH-1:0]     in_b;
    logic                 in_last;

    logic                 out_valid;
    logic                 out_ready;
    logic [ACC_WIDTH-1:0] out_sum;
    logic [CNT_WIDTH-1:0] out_count;
    logic                 out_error;

    logic                 g_start;
    logic [WIDTH-1:0]     g_a;
    logic [WIDTH-1:0]     g_b;
    logic [WIDTH-1:0]     g_result;
    logic                 g_done;

    modport slave (
        input  in_valid, in_a, in_b, in_last, out_ready, g_result, g_done,
        output in_ready, out_valid, out_sum, out_count, out_error, g_start, g_a, g_b
    );

    modport master (
        output in_valid, in_a, in_b, in_last, out_ready, g_result, g_done,
        input  in_ready, out_valid, out_sum, out_count, out_error, g_start, g_a, g_b
    );
endinterface

// File: rtl/dot_product_seq.sv
// Dot-product sequencer: issues one multiplier call per operand pair, accumulates
// the products and emits one sum per vector; a watchdog aborts a stalled call.
module dot_product_seq #(
    parameter int unsigned WIDTH     = 32,
    parameter int unsigned ACC_WIDTH = 40,
    parameter int unsigned CNT_WIDTH = 16,
    parameter int unsigned TIMEOUT   = 64
) (
    input  logic             clk,
    input  logic             reset,
    dot_product_seq_if.slave bus
);
    localparam int unsigned WD_WIDTH = $clog2(TIMEOUT);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CALL,
        S_WAIT,
        S_EMIT,
        S_DRAIN
    } state_e;

    state_e               state_q,     state_d;
    logic                 g_start_q,   g_start_d;
    logic [WIDTH-1:0]     g_a_q,       g_a_d;
    logic [WIDTH-1:0]     g_b_q,       g_b_d;
    logic [ACC_WIDTH-1:0] acc_q,       acc_d;
    logic [CNT_WIDTH-1:0] cnt_q,       cnt_d;
    logic [WD_WIDTH-1:0]  wd_q,        wd_d;
    logic                 last_q,      last_d;
    logic                 drain_q,     drain_d;
    logic                 out_valid_q, out_valid_d;
    logic [ACC_WIDTH-1:0] out_sum_q,   out_sum_d;
    logic [CNT_WIDTH-1:0] out_count_q, out_count_d;
    logic                 out_error_q, out_error_d;

    logic [ACC_WIDTH-1:0] acc_sum;
    logic [CNT_WIDTH-1:0] cnt_inc;

    // Products are unsigned 32-bit values; zero-extend into the accumulator.
    assign acc_sum = acc_q + ACC_WIDTH'(bus.g_result);
    assign cnt_inc = cnt_q + CNT_WIDTH'(1);

    assign bus.in_ready  = (state_q == S_IDLE) || (state_q == S_DRAIN);
    assign bus.out_valid = out_valid_q;
    assign bus.out_sum   = out_sum_q;
    assign bus.out_count = out_count_q;
    assign bus.out_error = out_error_q;
    assign bus.g_start   = g_start_q;
    assign bus.g_a       = g_a_q;
    assign bus.g_b       = g_b_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            g_start_q   <= 1'b0;
            g_a_q       <= '0;
            g_b_q       <= '0;
            acc_q       <= '0;
            cnt_q       <= '0;
            wd_q        <= '0;
            last_q      <= 1'b0;
            drain_q     <= 1'b0;
            out_valid_q <= 1'b0;
            out_sum_q   <= '0;
            out_count_q <= '0;
            out_error_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            g_start_q   <= g_start_d;
            g_a_q       <= g_a_d;
            g_b_q       <= g_b_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            wd_q        <= wd_d;
            last_q      <= last_d;
            drain_q     <= drain_d;
            out_valid_q <= out_valid_d;
            out_sum_q   <= out_sum_d;
            out_count_q <= out_count_d;
            out_error_q <= out_error_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        g_start_d   = g_start_q;
        g_a_d       = g_a_q;
        g_b_d       = g_b_q;
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        wd_d        = wd_q;
        last_d      = last_q;
        drain_d     = drain_q;
        out_valid_d = out_valid_q;
        out_sum_d   = out_sum_q;
        out_count_d = out_count_q;
        out_error_d = out_error_q;

        unique case (state_q)
            S_IDLE: begin
                if (bus.in_valid) begin
                    g_a_d     = bus.in_a;
                    g_b_d     = bus.in_b;
                    last_d    = bus.in_last;
                    g_start_d = 1'b1;
                    state_d   = S_CALL;
                end
            end
            S_CALL: begin
                g_start_d = 1'b0;
                wd_d      = '0;
                state_d   = S_WAIT;
            end
            S_WAIT: begin
                // A done on the final watchdog cycle still counts as an answer.
                if (bus.g_done) begin
                    acc_d = acc_sum;
                    cnt_d = cnt_inc;
                    if (last_q) begin
                        out_valid_d = 1'b1;
                        out_sum_d   = acc_sum;
                        out_count_d = cnt_inc;
                        out_error_d = 1'b0;
                        drain_d     = 1'b0;
                        state_d     = S_EMIT;
                    end else begin
                        state_d = S_IDLE;
                    end
                end else if (wd_q == WD_WIDTH'(TIMEOUT - 1)) begin
                    out_valid_d = 1'b1;
                    out_sum_d   = acc_q;
                    out_count_d = cnt_q;
                    out_error_d = 1'b1;
                    drain_d     = !last_q;
                    state_d     = S_EMIT;
                end else begin
                    wd_d = wd_q + WD_WIDTH'(1);
                end
            end
            S_EMIT: begin
                if (bus.out_ready) begin
                    out_valid_d = 1'b0;
                    out_error_d = 1'b0;
                    acc_d       = '0;
                    cnt_d       = '0;
                    drain_d     = 1'b0;
                    state_d     = drain_q ? S_DRAIN : S_IDLE;
                end
            end
            S_DRAIN: begin
                if (bus.in_valid && bus.in_last) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end
endmodule

// File: tb/tb_dot_product_seq.sv
// Scoreboard bench for dot_product_seq with a 3-cycle multiplier stub that can be
// muted to exercise the watchdog abort and drain path.
module tb_dot_product_seq;
    localparam int unsigned W  = 32;
    localparam int unsigned AW = 33;
    localparam int unsigned CW = 16;
    localparam int unsigned TO = 16;

    typedef struct packed {
        logic [AW-1:0] sum;
        logic [CW-1:0] cnt;
        logic          err;
    } exp_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    dot_product_seq_if #(.WIDTH(W), .ACC_WIDTH(AW), .CNT_WIDTH(CW)) bus ();

    dot_product_seq #(.WIDTH(W), .ACC_WIDTH(AW), .CNT_WIDTH(CW), .TIMEOUT(TO)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_vec = 0;
    int n_err = 0;
    int n_out = 0;
    int cyc = 0;
    int gs_cnt = 0;
    int acc_cyc = 0;
    exp_t sb_q[$];
    logic [AW-1:0] sb_acc = '0;
    logic [CW-1:0] sb_cnt = '0;

    // Multiplier stub: start seen at E1, operands captured at E2, result/done at E3.
    logic mul_mute = 1'b0;
    logic m_s1, m_s2;
    logic [W-1:0] m_a, m_b;
    always @(posedge clk) begin
        if (reset) begin
            m_s1 <= 1'b0;
            m_s2 <= 1'b0;
            bus.g_done   <= 1'b0;
            bus.g_result <= '0;
        end else begin
            m_s1 <= bus.g_start;
            m_s2 <= m_s1;
            if (m_s1) begin
                m_a <= bus.g_a;
                m_b <= bus.g_b;
            end
            if (bus.g_start) bus.g_done <= 1'b0;
            else if (m_s2 && !mul_mute) begin
                bus.g_result <= W'(m_a * m_b);
                bus.g_done   <= 1'b1;
            end
        end
    end

    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) if (bus.g_start) gs_cnt <= gs_cnt + 1;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (!reset && bus.out_valid && bus.out_ready) begin
            n_out++;
            if (sb_q.size() == 0) check("sb_underflow", 64'(sb_q.size()), 64'd1);
            else begin
                e = sb_q.pop_front();
                check("out_sum", 64'(bus.out_sum), 64'(e.sum));
                check("out_count", 64'(bus.out_count), 64'(e.cnt));
                check("out_error", 64'(bus.out_error), 64'(e.err));
            end
        end
    end

    task automatic push_exp(input logic [AW-1:0] s, input logic [CW-1:0] c, input logic er);
        exp_t e;
        e.sum = s;
        e.cnt = c;
        e.err = er;
        sb_q.push_back(e);
    endtask

    // Drive one pair and return 1 ns after the accepting edge.
    task automatic send_pair(input logic [W-1:0] a, input logic [W-1:0] b,
                             input logic last, input bit model);
        int budget = 200;
        logic [W-1:0] prod;
        bus.in_valid = 1'b1;
        bus.in_a     = a;
        bus.in_b     = b;
        bus.in_last  = last;
        while (!bus.in_ready && budget > 0) begin
            @(posedge clk); #1;
            budget--;
        end
        if (!bus.in_ready) check("in_ready_timeout", 64'(bus.in_ready), 64'd1);
        @(posedge clk); #1;
        acc_cyc = cyc;
        bus.in_valid = 1'b0;
        if (model) begin
            prod   = W'(a * b);
            sb_acc = sb_acc + AW'(prod);
            sb_cnt = sb_cnt + CW'(1);
            if (last) begin
                push_exp(sb_acc, sb_cnt, 1'b0);
                sb_acc = '0;
                sb_cnt = '0;
            end
        end
    endtask

    task automatic wait_valid(output int lat);
        int budget = 100;
        while (!bus.out_valid && budget > 0) begin
            @(posedge clk); #1;
            budget--;
        end
        if (!bus.out_valid) check("out_valid_timeout", 64'(bus.out_valid), 64'd1);
        lat = cyc - acc_cyc;
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_in_ready"}, 64'(bus.in_ready), 64'd1);
        check({tag, "_out_valid"}, 64'(bus.out_valid), 64'd0);
        check({tag, "_out_sum"}, 64'(bus.out_sum), 64'd0);
        check({tag, "_out_count"}, 64'(bus.out_count), 64'd0);
        check({tag, "_out_error"}, 64'(bus.out_error), 64'd0);
        check({tag, "_g_start"}, 64'(bus.g_start), 64'd0);
        check({tag, "_g_a"}, 64'(bus.g_a), 64'd0);
        check({tag, "_g_b"}, 64'(bus.g_b), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got time %0t expected finish", $time);
        $fatal(1, "bench timeout");
    end

    initial begin
        int lat, c0, g0;
        bus.in_valid  = 1'b0;
        bus.in_a      = '0;
        bus.in_b      = '0;
        bus.in_last   = 1'b0;
        bus.out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_reset_state("rst");
        reset = 1'b0;

        // Single pair 3*4.
        g0 = gs_cnt;
        send_pair(32'd3, 32'd4, 1'b1, 1'b1);
        check("t1_gstart_hi", 64'(bus.g_start), 64'd1);
        @(posedge clk); #1;
        check("t1_gstart_lo", 64'(bus.g_start), 64'd0);
        wait_valid(lat);
        check("t1_latency", 64'(lat), 64'd4);
        repeat (2) @(posedge clk);
        #1;
        check("t1_gstart_cycles", 64'(gs_cnt - g0), 64'd1);

        // Three-term vector with back-to-back valid: 6+20+42.
        send_pair(32'd2, 32'd3, 1'b0, 1'b1);
        c0 = acc_cyc;
        send_pair(32'd4, 32'd5, 1'b0, 1'b1);
        check("t2_spacing", 64'(acc_cyc - c0), 64'd5);
        c0 = acc_cyc;
        send_pair(32'd6, 32'd7, 1'b1, 1'b1);
        check("t2_spacing2", 64'(acc_cyc - c0), 64'd5);
        wait_valid(lat);
        check("t2_latency", 64'(lat), 64'd4);

        // Product truncation and accumulator wrap at 33 bits.
        send_pair(32'h0001_0000, 32'h0001_0000, 1'b1, 1'b1);
        wait_valid(lat);
        send_pair(32'hFFFF_FFFF, 32'd1, 1'b0, 1'b1);
        send_pair(32'hFFFF_FFFF, 32'd1, 1'b0, 1'b1);
        send_pair(32'hFFFF_FFFF, 32'd1, 1'b1, 1'b1);
        wait_valid(lat);

        // Output backpressure.
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        send_pair(32'd9, 32'd9, 1'b1, 1'b1);
        wait_valid(lat);
        for (int i = 0; i < 10; i++) begin
            check("bp_valid", 64'(bus.out_valid), 64'd1);
            check("bp_sum", 64'(bus.out_sum), 64'd81);
            check("bp_in_ready", 64'(bus.in_ready), 64'd0);
            @(posedge clk); #1;
        end
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        check("bp_release", 64'(bus.out_valid), 64'd0);

        // Watchdog abort on the first of three pairs, remaining pairs drained.
        mul_mute = 1'b1;
        g0 = gs_cnt;
        send_pair(32'd1, 32'd2, 1'b0, 1'b0);
        push_exp('0, '0, 1'b1);
        wait_valid(lat);
        check("to_latency", 64'(lat), 64'(TO + 1));
        check("to_error_flag", 64'(bus.out_error), 64'd1);
        mul_mute = 1'b0;
        send_pair(32'd3, 32'd3, 1'b0, 1'b0);
        send_pair(32'd4, 32'd4, 1'b1, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        check("to_drain_no_call", 64'(gs_cnt - g0), 64'd1);
        send_pair(32'd2, 32'd2, 1'b1, 1'b1);
        wait_valid(lat);
        check("to_recover_latency", 64'(lat), 64'd4);

        // Reset while waiting on the multiplier.
        @(posedge clk); #1;
        send_pair(32'd7, 32'd8, 1'b1, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        check_reset_state("mid_rst");
        send_pair(32'd5, 32'd6, 1'b1, 1'b1);
        wait_valid(lat);
        repeat (3) @(posedge clk);
        #1;
        check("sb_drained", 64'(sb_q.size()), 64'd0);
        check("outputs_seen", 64'(n_out), 64'd8);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
